// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of request, source-data and arbitrated-output signals shared by the
// four requesters, the round-robin arbiter and the downstream consumer.
interface mux4_rr_arbiter_if #(
  parameter int n = 3
);
  logic [3:0]   req;
  logic [n-1:0] x;
  logic [n-1:0] y;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic [n-1:0] f;
  logic         f_valid;
  logic         busy;

  modport master (
    output req, x, y, a, b,
    input  gnt, sel, f, f_valid, busy
  );

  modport slave (
    input  req, x, y, a, b,
    output gnt, sel, f, f_valid, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered 4:1 mux among four
// requesters, with a bounded hold time whenever another requester is waiting.
module mux4_rr_arbiter #(
  parameter int n        = 3,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mux4_rr_arbiter_if.slave  bus
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t       state, state_n;
  logic [3:0]   gnt, gnt_n;
  logic [1:0]   sel, sel_n;
  logic [1:0]   ptr, ptr_n;
  logic [n-1:0] f, f_n;
  logic         f_valid, f_valid_n;
  logic [HW-1:0] hold_cnt, hold_n;

  logic [n-1:0] data_sel;
  logic [3:0]   others;
  logic [2:0]   idle_pick;
  logic [2:0]   next_pick;
  logic         release_now;

  // Returns {found, index} of the first set bit of r scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] k;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      k = start + 2'(i);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    data_sel = bus.x;
    case (sel)
      2'd0: data_sel = bus.x;
      2'd1: data_sel = bus.y;
      2'd2: data_sel = bus.a;
      2'd3: data_sel = bus.b;
      default: data_sel = bus.x;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      ptr      <= 2'd0;
      f        <= '0;
      f_valid  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      ptr      <= ptr_n;
      f        <= f_n;
      f_valid  <= f_valid_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    sel_n       = sel;
    ptr_n       = ptr;
    f_n         = f;
    f_valid_n   = f_valid;
    hold_n      = hold_cnt;
    others      = bus.req & ~(4'b0001 << sel);
    idle_pick   = pick(bus.req, ptr);
    next_pick   = pick(others, sel + 2'd1);
    release_now = !bus.req[sel] || ((hold_cnt == HW'(HOLD_MAX)) && (|others));

    case (state)
      IDLE: begin
        f_valid_n = 1'b0;
        if (idle_pick[2]) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << idle_pick[1:0];
          sel_n   = idle_pick[1:0];
          hold_n  = HW'(1);
        end
      end

      GRANT: begin
        // A preempted owner still transfers its final word on the handoff edge.
        if (bus.req[sel]) begin
          f_n       = data_sel;
          f_valid_n = 1'b1;
        end else begin
          f_valid_n = 1'b0;
        end

        if (release_now) begin
          ptr_n = sel + 2'd1;
          if (next_pick[2]) begin
            gnt_n  = 4'b0001 << next_pick[1:0];
            sel_n  = next_pick[1:0];
            hold_n = HW'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            hold_n  = '0;
          end
        end else if (hold_cnt < HW'(HOLD_MAX)) begin
          hold_n = hold_cnt + HW'(1);
        end
      end

      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  assign bus.gnt     = gnt;
  assign bus.sel     = sel;
  assign bus.f       = f;
  assign bus.f_valid = f_valid;
  assign bus.busy    = (state == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic compared each
// cycle against a queue-free integer model of the round-robin rules.
module tb_mux4_rr_arbiter;

  localparam int N        = 3;
  localparam int HOLD_MAX = 4;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mux4_rr_arbiter_if #(.n(N)) bus ();

  mux4_rr_arbiter #(.n(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner -1 means idle; held counts grant cycles without saturation.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic [N-1:0] m_f   = '0;
  logic       m_fv    = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [N-1:0] src [4];
    logic [3:0]   oth;
    int           own;
    if (reset) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_f     = '0;
      m_fv    = 1'b0;
    end else begin
      src = '{bus.x, bus.y, bus.a, bus.b};
      own = m_owner;
      if (own < 0) begin
        m_fv = 1'b0;
        if (bus.req != 4'b0000) begin
          m_owner = first_from(bus.req, m_ptr);
          m_held  = 1;
        end
      end else begin
        if (bus.req[own]) begin
          m_f  = src[own];
          m_fv = 1'b1;
        end else begin
          m_fv = 1'b0;
        end
        oth = bus.req;
        oth[own] = 1'b0;
        if (!bus.req[own] || (m_held >= HOLD_MAX && oth != 4'b0000)) begin
          m_ptr = (own + 1) % 4;
          if (oth != 4'b0000) begin
            m_owner = first_from(oth, m_ptr);
            m_held  = 1;
          end else begin
            m_owner = -1;
            m_held  = 0;
          end
        end else begin
          m_held++;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    checkOutput("gnt", 8'(bus.gnt), 8'(exp_gnt));
    checkOutput("busy", 8'(bus.busy), 8'(m_owner >= 0));
    if (m_owner >= 0) checkOutput("sel", 8'(bus.sel), 8'(m_owner));
    checkOutput("f_valid", 8'(bus.f_valid), 8'(m_fv));
    checkOutput("f", 8'(bus.f), 8'(m_f));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [N-1:0] vx, input logic [N-1:0] vy,
                               input logic [N-1:0] va, input logic [N-1:0] vb);
    @(negedge clk);
    bus.req = r;
    bus.x   = vx;
    bus.y   = vy;
    bus.a   = va;
    bus.b   = vb;
    @(posedge clk);
    #2;
    compareModel();
  endtask

  // Pulses reset between edges and checks that outputs clear without a clock edge.
  task automatic pulseReset();
    @(negedge clk);
    bus.req = 4'b0000;
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_gnt", 8'(bus.gnt), 8'h0);
    checkOutput("rst_sel", 8'(bus.sel), 8'h0);
    checkOutput("rst_f", 8'(bus.f), 8'h0);
    checkOutput("rst_f_valid", 8'(bus.f_valid), 8'h0);
    checkOutput("rst_busy", 8'(bus.busy), 8'h0);
    #1 reset = 1'b0;
    @(posedge clk);
    #2;
    compareModel();
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    logic [3:0] r;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset   = 1'b1;
    bus.req = 4'b0000;
    bus.x   = '0;
    bus.y   = '0;
    bus.a   = '0;
    bus.b   = '0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("init_gnt", 8'(bus.gnt), 8'h0);
    checkOutput("init_f_valid", 8'(bus.f_valid), 8'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single requester latency");
    applyStimulus(4'b0001, 3'd5, 3'd1, 3'd2, 3'd3);
    checkOutput("t1_gnt", 8'(bus.gnt), 8'h1);
    checkOutput("t1_sel", 8'(bus.sel), 8'h0);
    checkOutput("t1_fv0", 8'(bus.f_valid), 8'h0);
    applyStimulus(4'b0001, 3'd5, 3'd1, 3'd2, 3'd3);
    checkOutput("t1_f", 8'(bus.f), 8'h5);
    checkOutput("t1_fv1", 8'(bus.f_valid), 8'h1);

    $display("[TB] all requesting, rotating slots");
    pulseReset();
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(4'b1111, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
      checkOutput("t2_nogap", 8'(bus.gnt != 4'b0000), 8'h1);
      if ((k - 1) % 4 == 0) checkOutput("t2_slot", 8'(bus.gnt), 8'(exp_seq[(k - 1) / 4]));
    end

    $display("[TB] lone requester holds indefinitely");
    pulseReset();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b0100, N'($urandom), N'($urandom), 3'd3, N'($urandom));
      checkOutput("t3_gnt", 8'(bus.gnt), 8'h4);
    end
    checkOutput("t3_f", 8'(bus.f), 8'h3);

    $display("[TB] owner drop hands over without gap");
    pulseReset();
    applyStimulus(4'b0001, 3'd2, 3'd0, 3'd0, 3'd6);
    applyStimulus(4'b1001, 3'd2, 3'd0, 3'd0, 3'd6);
    applyStimulus(4'b1000, 3'd2, 3'd0, 3'd0, 3'd6);
    checkOutput("t4_gnt", 8'(bus.gnt), 8'h8);
    checkOutput("t4_sel", 8'(bus.sel), 8'h3);
    checkOutput("t4_fv0", 8'(bus.f_valid), 8'h0);
    applyStimulus(4'b1000, 3'd2, 3'd0, 3'd0, 3'd6);
    checkOutput("t4_f", 8'(bus.f), 8'h6);
    checkOutput("t4_fv1", 8'(bus.f_valid), 8'h1);

    $display("[TB] reset mid-grant, pointer back to zero");
    pulseReset();
    applyStimulus(4'b0110, 3'd0, 3'd1, 3'd2, 3'd3);
    checkOutput("t5_gnt", 8'(bus.gnt), 8'h2);

    $display("[TB] pointer wrap");
    applyStimulus(4'b1000, 3'd0, 3'd1, 3'd2, 3'd3);
    checkOutput("t6_gnt3", 8'(bus.gnt), 8'h8);
    applyStimulus(4'b0000, 3'd0, 3'd1, 3'd2, 3'd3);
    checkOutput("t6_idle", 8'(bus.gnt), 8'h0);
    applyStimulus(4'b1001, 3'd0, 3'd1, 3'd2, 3'd3);
    checkOutput("t6_wrap", 8'(bus.gnt), 8'h1);
    applyStimulus(4'b0000, 3'd0, 3'd1, 3'd2, 3'd3);
    applyStimulus(4'b1001, 3'd0, 3'd1, 3'd2, 3'd3);
    checkOutput("t6_ptr1", 8'(bus.gnt), 8'h8);

    $display("[TB] randomized traffic");
    r = 4'($urandom);
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom);
      if (k % 97 == 96) pulseReset();
      applyStimulus(r, N'($urandom), N'($urandom), N'($urandom), N'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
